spi_master_slave: RTL and testbench
===================================

SPI_MASTER_SLAVE -- requirements
Module: spi_master_slave

Interface
- REQ-001 clk  input  1  single system clock; all state updates on rising edge.
- REQ-002 reset  input  1  asynchronous, active-low reset.
- REQ-003 start  input  1  level request from host to begin one byte transfer.
- REQ-004 data_in  input  8  byte the master transmits on mosi.
- REQ-005 slave_data_in  input  8  byte the slave returns on miso.
- REQ-006 buzy  output  1  high while the master is not IDLE.
- REQ-007 done  output  1  one-cycle pulse when the master byte completes.
- REQ-008 data_out  output  8  byte the master received on miso; held until the next done.
- REQ-009 slave_data_out  output  8  byte the slave received on mosi; held until the next slave_done.
- REQ-010 slave_done  output  1  one-cycle pulse when the slave byte completes.
- REQ-011 cs, sclk, mosi, miso  output  1 each  internal SPI wires, exported for observation; cs active-low.
- REQ-012 Parameter CLK_DIV, default 2, meaning clk cycles per sclk period; must be even and >= 2.

Function
- REQ-013 The SPI link SHALL use mode 0: sclk idles low, data is sampled on the sclk rise and changed on the sclk fall, MSB first, 8 bits, full duplex.
- REQ-014 The master FSM SHALL have states IDLE, XFER and DONE.
- REQ-015 IDLE->XFER SHALL occur on a start rising edge (start high, previous start low) seen in IDLE; on the next cycle cs=0, mosi=data_in[7], and the master shift register loads data_in.
- REQ-016 A start held high for any number of cycles SHALL produce exactly one transfer.
- REQ-017 A start edge seen outside IDLE SHALL be ignored.
- REQ-018 In XFER the master SHALL generate exactly 8 sclk pulses, sampling miso on each rise and presenting the next bit on each fall.
- REQ-019 With CLK_DIV=2, XFER SHALL last exactly 16 cycles.
- REQ-020 XFER->DONE SHALL raise cs, update data_out, and pulse done for 1 cycle; DONE->IDLE follows unconditionally.
- REQ-021 Total latency from the accepted start edge to done SHALL be CLK_DIV*8+2 cycles, i.e. 18 cycles at the default.
- REQ-022 The slave SHALL run on clk and detect sclk and cs edges by comparing registered copies; no clocking on sclk.
- REQ-023 On the cs falling edge the slave SHALL load slave_data_in and drive miso=slave_data_in[7].
- REQ-024 The slave SHALL shift mosi in on each detected sclk rise and present its next bit on each detected sclk fall.
- REQ-025 On the cs rising edge the slave SHALL update slave_data_out and pulse slave_done for 1 cycle, at most 2 cycles after done.
- REQ-026 If cs rises after fewer than 8 bits, the slave SHALL discard the partial byte with no slave_done and slave_data_out unchanged.
- REQ-027 miso SHALL be 0 while cs is high.
- REQ-028 data_in and slave_data_in SHALL be sampled only at load; later changes do not affect the byte in flight.

Reset
- REQ-029 Asserting reset, including mid-transfer, SHALL immediately force the master to IDLE, the slave to idle, and: cs=1, sclk=0, mosi=0, miso=0, buzy=0, done=0, slave_done=0, data_out=0, slave_data_out=0, all shift registers and bit counters 0.
- REQ-030 After reset, the first start rising edge SHALL be required before any transfer begins.

Structure
- REQ-031 A shared package SHALL hold the master state enum, CLK_DIV default and the byte width constant (8).
- REQ-032 spi_master_slave SHALL contain a master FSM and a slave FSM, each using one sub-module spi_shift8: an 8-bit load/shift register with serial in, serial out and parallel out.

Verification
- REQ-033 Reset low, then high; data_in=0x2B, start high 2 cycles -> done 18 cycles after the edge, slave_data_out=0x2B, one slave_done.
- REQ-034 Send the 16-byte key 2b7e1516 28aed2a6 abf71588 09cf4f3c, one byte per 36-cycle slot -> every slave_data_out byte matches.
- REQ-035 data_in=0xA5, slave_data_in=0x3C -> data_out=0x3C, slave_data_out=0xA5 (full duplex).
- REQ-036 start held high 40 cycles -> exactly one done and one slave_done.
- REQ-037 Assert reset at bit 4 of a 0xFF transfer -> cs=1, buzy=0 immediately, no done, no slave_done, slave_data_out unchanged.
- REQ-038 start edge during XFER -> ignored; exactly one done.

Source files
------------

// File: rtl/spi_master_slave_pkg.sv
// Shared constants and state encodings for the SPI master/slave loopback block.
package spi_master_slave_pkg;

  // Bits per SPI transfer.
  localparam int BYTE_W      = 8;
  // Default number of clk cycles per sclk period (even, >= 2).
  localparam int CLK_DIV_DEF = 2;

  // Master FSM: wait for a start edge, clock out one byte, flag completion.
  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_XFER = 2'd1,
    M_DONE = 2'd2
  } mst_state_e;

  // Slave FSM: deselected, or selected and tracking sclk edges.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEL  = 1'b1
  } slv_state_e;

  // Width of a counter that must hold values 0 .. n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_shift8.sv
// 8-bit load/shift register: parallel load, MSB-first serial out, serial in at LSB.
module spi_shift8
  import spi_master_slave_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              shift_i,
  input  logic              sin_i,
  output logic [BYTE_W-1:0] q_o,
  output logic              sout_o
);

  logic [BYTE_W-1:0] q_q, q_d;

  // Load wins over shift; shifting moves toward the MSB and pulls sin_i into bit 0.
  always_comb begin
    q_d = q_q;
    if (load_i)       q_d = data_i;
    else if (shift_i) q_d = {q_q[BYTE_W-2:0], sin_i};
  end

  // Register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o    = q_q;
  assign sout_o = q_q[BYTE_W-1];

endmodule

// File: rtl/spi_master_slave.sv
// SPI mode-0 master and slave joined back to back on one clk; the SPI wires
// are exported for observation. The slave never clocks on sclk: it finds
// sclk/cs edges by comparing each wire with its registered copy.
module spi_master_slave
  import spi_master_slave_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] data_in,
  input  logic [BYTE_W-1:0] slave_data_in,
  output logic              buzy,
  output logic              done,
  output logic [BYTE_W-1:0] data_out,
  output logic [BYTE_W-1:0] slave_data_out,
  output logic              slave_done,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  output logic              miso
);

  localparam int                 HALF     = CLK_DIV / 2;
  localparam int                 DIV_W    = cnt_w(CLK_DIV);
  localparam int                 BIT_W    = $clog2(BYTE_W);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   HALF_V   = DIV_W'(HALF);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(BYTE_W - 1);
  localparam logic [BIT_W:0]     CNT_FULL = (BIT_W + 1)'(BYTE_W);

  // ---------------------------------------------------------------- master
  mst_state_e        m_state_q, m_state_d;
  logic              start_q, start_qq, start_edge;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              m_load, m_shift, m_last, m_sout;
  logic [BYTE_W-1:0] m_par;
  logic [BYTE_W-1:0] data_out_q, data_out_d;

  // Start history resets high so a start held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q  <= 1'b1;
      start_qq <= 1'b1;
    end else begin
      start_q  <= start;
      start_qq <= start_q;
    end
  end

  assign start_edge = start_q & ~start_qq;
  // The shift at the end of each high phase both samples miso and presents the next mosi bit.
  assign m_shift    = (m_state_q == M_XFER) && (div_q == DIV_LAST);
  assign m_last     = m_shift && (bit_q == BIT_LAST);

  // Master state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) m_state_q <= M_IDLE;
    else        m_state_q <= m_state_d;
  end

  // Master next-state: start edges outside IDLE are ignored.
  always_comb begin
    m_state_d = m_state_q;
    unique case (m_state_q)
      M_IDLE:  if (start_edge) m_state_d = M_XFER;
      M_XFER:  if (m_last)     m_state_d = M_DONE;
      M_DONE:                  m_state_d = M_IDLE;
      default:                 m_state_d = M_IDLE;
    endcase
  end

  // Master outputs; during DONE data_out already shows the freshly received byte.
  always_comb begin
    buzy     = (m_state_q != M_IDLE);
    done     = (m_state_q == M_DONE);
    cs       = (m_state_q != M_XFER);
    sclk     = (m_state_q == M_XFER) && (div_q >= HALF_V);
    mosi     = (m_state_q == M_XFER) && m_sout;
    m_load   = (m_state_q == M_IDLE) && start_edge;
    data_out = (m_state_q == M_DONE) ? m_par : data_out_q;
  end

  // sclk phase divider and bit counter, parked at zero outside XFER.
  always_comb begin
    div_d      = '0;
    bit_d      = '0;
    data_out_d = data_out_q;
    if (m_state_q == M_XFER) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      bit_d = m_shift ? bit_q + BIT_W'(1) : bit_q;
    end
    if (m_state_q == M_DONE) data_out_d = m_par;
  end

  // Master counters and held result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      bit_q      <= '0;
      data_out_q <= '0;
    end else begin
      div_q      <= div_d;
      bit_q      <= bit_d;
      data_out_q <= data_out_d;
    end
  end

  spi_shift8 u_mst_sr (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (m_load),
    .data_i  (data_in),
    .shift_i (m_shift),
    .sin_i   (miso),
    .q_o     (m_par),
    .sout_o  (m_sout)
  );

  // ----------------------------------------------------------------- slave
  slv_state_e        s_state_q, s_state_d;
  logic              cs_prev_q, sclk_prev_q;
  logic              cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic              s_load, s_shift, s_sout;
  logic [BYTE_W-1:0] s_par;
  logic [BIT_W:0]    s_cnt_q, s_cnt_d;
  logic              miso_q, miso_d;
  logic [BYTE_W-1:0] sdo_q, sdo_d;
  logic              sdone_q, sdone_d;

  // Registered copies of the SPI wires for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_prev_q   <= cs;
      sclk_prev_q <= sclk;
    end
  end

  assign cs_fall   =  cs_prev_q & ~cs;
  assign cs_rise   = ~cs_prev_q &  cs;
  assign sclk_rise = ~sclk_prev_q &  sclk;
  assign sclk_fall =  sclk_prev_q & ~sclk;

  // Slave state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s_state_q <= S_IDLE;
    else        s_state_q <= s_state_d;
  end

  // Slave next-state: selected between cs fall and cs rise.
  always_comb begin
    s_state_d = s_state_q;
    unique case (s_state_q)
      S_IDLE:  if (cs_fall) s_state_d = S_SEL;
      S_SEL:   if (cs_rise) s_state_d = S_IDLE;
      default:              s_state_d = S_IDLE;
    endcase
  end

  // Slave outputs: shift in mosi on sclk rise; miso is forced low while deselected.
  always_comb begin
    s_load  = (s_state_q == S_IDLE) && cs_fall;
    s_shift = (s_state_q == S_SEL) && sclk_rise && (s_cnt_q != CNT_FULL);
    miso    = miso_q & ~cs;
  end

  // Slave datapath: the shift register moves on sclk rise, but miso only
  // changes on sclk fall, so the bit held on miso is the pre-rise MSB.
  always_comb begin
    s_cnt_d = s_cnt_q;
    miso_d  = miso_q;
    sdo_d   = sdo_q;
    sdone_d = 1'b0;
    if (s_load) begin
      s_cnt_d = '0;
      miso_d  = slave_data_in[BYTE_W-1];
    end else if (s_state_q == S_SEL) begin
      if (cs_rise) begin
        s_cnt_d = '0;
        miso_d  = 1'b0;
        // A short frame is dropped silently.
        if (s_cnt_q == CNT_FULL) begin
          sdo_d   = s_par;
          sdone_d = 1'b1;
        end
      end else begin
        if (s_shift)   s_cnt_d = s_cnt_q + (BIT_W + 1)'(1);
        if (sclk_fall) miso_d  = s_sout;
      end
    end
  end

  // Slave registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_cnt_q <= '0;
      miso_q  <= 1'b0;
      sdo_q   <= '0;
      sdone_q <= 1'b0;
    end else begin
      s_cnt_q <= s_cnt_d;
      miso_q  <= miso_d;
      sdo_q   <= sdo_d;
      sdone_q <= sdone_d;
    end
  end

  assign slave_data_out = sdo_q;
  assign slave_done     = sdone_q;

  spi_shift8 u_slv_sr (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (s_load),
    .data_i  (slave_data_in),
    .shift_i (s_shift),
    .sin_i   (mosi),
    .q_o     (s_par),
    .sout_o  (s_sout)
  );

endmodule

// File: tb/tb_spi_master_slave.sv
// Scoreboard bench: each issued transfer pushes the swapped bytes and its
// start cycle; a negedge monitor pops and checks whenever done/slave_done fire.
module tb_spi_master_slave;

  localparam int CLK_DIV = 2;
  localparam int LAT     = CLK_DIV * 8 + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] slave_data_in = 8'h00;
  logic       buzy, done, slave_done, cs, sclk, mosi, miso;
  logic [7:0] data_out, slave_data_out;

  spi_master_slave #(.CLK_DIV(CLK_DIV)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .data_in        (data_in),
    .slave_data_in  (slave_data_in),
    .buzy           (buzy),
    .done           (done),
    .data_out       (data_out),
    .slave_data_out (slave_data_out),
    .slave_done     (slave_done),
    .cs             (cs),
    .sclk           (sclk),
    .mosi           (mosi),
    .miso           (miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_issued = 0, n_done = 0, n_sdone = 0;
  logic [7:0] exp_m[$];   // byte the master should receive
  logic [7:0] exp_s[$];   // byte the slave should receive
  int         exp_t[$];   // cycle the start was raised

  logic [7:0] key [16] = '{8'h2b, 8'h7e, 8'h15, 8'h16, 8'h28, 8'hae, 8'hd2, 8'ha6,
                           8'hab, 8'hf7, 8'h15, 8'h88, 8'h09, 8'hcf, 8'h4f, 8'h3c};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  int         nrise = 0, last_done = -100, mon_t;
  logic [7:0] mon_b;
  logic       sclk_p = 1'b0, cs_p = 1'b1, done_p = 1'b0, sd_p = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      nrise = 0; sclk_p = 1'b0; cs_p = 1'b1; done_p = 1'b0; sd_p = 1'b0;
    end else begin
      if (!cs && cs_p) nrise = 0;
      if (sclk && !sclk_p) nrise++;
      if (cs) begin
        chk("miso_idle", int'(miso), 0);
        chk("sclk_idle", int'(sclk), 0);
      end
      if (done) begin
        n_done++;
        chk("done_pulse", int'(done_p), 0);
        if (exp_m.size() == 0) chk("unexpected_done", exp_m.size(), 1);
        else begin
          mon_b = exp_m.pop_front();
          mon_t = exp_t.pop_front();
          chk("data_out", int'(data_out), int'(mon_b));
          chk("latency", cyc - mon_t, LAT);
          chk("sclk_pulses", nrise, 8);
        end
        last_done = cyc;
      end
      if (slave_done) begin
        n_sdone++;
        chk("slave_done_pulse", int'(sd_p), 0);
        if (exp_s.size() == 0) chk("unexpected_slave_done", exp_s.size(), 1);
        else begin
          mon_b = exp_s.pop_front();
          chk("slave_data_out", int'(slave_data_out), int'(mon_b));
          chk("slave_done_lag", int'((cyc - last_done) >= 1 && (cyc - last_done) <= 2), 1);
        end
      end
      sclk_p = sclk; cs_p = cs; done_p = done; sd_p = slave_done;
    end
  end

  // --------------------------------------------------------------- stimulus
  // One transfer slot: start high for 'hold' cycles, optional second start
  // pulse at cycle 'reedge', inputs scrambled after load to prove sampling.
  task automatic xfer(input logic [7:0] m, input logic [7:0] s,
                      input int hold, input int slot, input int reedge);
    @(posedge clk); #1;
    data_in = m; slave_data_in = s; start = 1'b1;
    exp_m.push_back(s);
    exp_s.push_back(m);
    exp_t.push_back(cyc);
    n_issued++;
    for (int c = 1; c < slot; c++) begin
      @(posedge clk); #1;
      if (c == hold) start = 1'b0;
      if (c == reedge) start = 1'b1;
      if (c == reedge + 1) start = 1'b0;
      if (c == 4) begin
        data_in = 8'($urandom);
        slave_data_in = 8'($urandom);
      end
    end
  endtask

  int saved_done, saved_sdone;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", int'(cs), 1);
    chk("rst_sclk", int'(sclk), 0);
    chk("rst_mosi", int'(mosi), 0);
    chk("rst_miso", int'(miso), 0);
    chk("rst_buzy", int'(buzy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_slave_done", int'(slave_done), 0);
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_slave_data_out", int'(slave_data_out), 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);

    xfer(8'h2B, 8'($urandom), 2, 36, -10);
    for (int i = 0; i < 16; i++) xfer(key[i], 8'($urandom), 1 + $urandom_range(0, 3), 36, -10);
    xfer(8'hA5, 8'h3C, 2, 36, -10);
    xfer(8'($urandom), 8'($urandom), 40, 60, -10);   // long start level
    xfer(8'($urandom), 8'($urandom), 1, 36, 6);      // second edge mid-transfer
    xfer(8'h00, 8'hFF, 1, 24, -10);
    xfer(8'hFF, 8'h00, 1, 24, -10);
    for (int i = 0; i < 10; i++)
      xfer(8'($urandom), 8'($urandom), 1 + $urandom_range(0, 4), 22 + $urandom_range(0, 6), -10);

    // Reset at bit 4 of a 0xFF transfer; nothing is expected to complete.
    saved_done = n_done;
    saved_sdone = n_sdone;
    @(posedge clk); #1;
    data_in = 8'hFF; slave_data_in = 8'($urandom); start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_reset_buzy", int'(buzy), 1);
    reset = 1'b0;
    #1;
    chk("midrst_cs", int'(cs), 1);
    chk("midrst_buzy", int'(buzy), 0);
    chk("midrst_sclk", int'(sclk), 0);
    chk("midrst_mosi", int'(mosi), 0);
    chk("midrst_miso", int'(miso), 0);
    chk("midrst_slave_data_out", int'(slave_data_out), 0);
    chk("midrst_data_out", int'(data_out), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    // start still high: no transfer until a fresh rising edge.
    repeat (30) @(posedge clk);
    #1;
    chk("no_xfer_after_reset", int'(buzy), 0);
    chk("no_done_after_reset", n_done, saved_done);
    chk("no_slave_done_after_reset", n_sdone, saved_sdone);
    start = 1'b0;
    repeat (3) @(posedge clk);
    xfer(8'($urandom), 8'($urandom), 2, 36, -10);

    repeat (5) @(posedge clk);
    #1;
    chk("master_queue_drained", exp_m.size(), 0);
    chk("slave_queue_drained", exp_s.size(), 0);
    chk("done_count", n_done, n_issued);
    chk("slave_done_count", n_sdone, n_issued);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
